// File: rtl/data_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_ser_pkg
// Brief  : Shared types and helpers for the byte serializer.
//          - serState_t : serializer FSM state encoding
//          - maxOf      : larger of two integers
//          - widthFor   : bits needed to hold the values 0..maxVal
// Rev    : 1.0  initial release
// ============================================================================
package data_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } serState_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Never returns less than one bit so that a counter whose only value is
  // zero still has a legal width.
  function automatic int widthFor(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_timer.sv
`default_nettype none
// ============================================================================
// Module : ser_timer
// Brief  : Loadable down-counter with freeze input and zero flag.
//          Counting stops at zero, so the counter never wraps.
// Ports  : pclk    - clock (rising edge)
//          rstn    - asynchronous active-low reset, clears the count
//          load    - load loadVal this cycle (takes priority over hold)
//          loadVal - value to load
//          hold    - freeze the count
//          zero    - count is zero
// Rev    : 1.0  initial release
// ============================================================================
module ser_timer #(
  parameter int WIDTH = 1
) (
  input  logic             pclk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             hold,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadVal;
    end else if (!hold && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/data_serializer.sv
`default_nettype none
// ============================================================================
// Module : data_serializer
// Brief  : Sends a parallel word out one byte at a time. Each byte is shown
//          on dout with ready high for OUT_CLOCK cycles, followed by
//          GAP_CLOCK cycles with ready low. out_hold freezes the timing.
// Ports  : pclk     - clock (rising edge)
//          rstn     - asynchronous active-low reset
//          din      - parallel word, byte 0 at the LSB end
//          nbytes   - bytes to send from byte 0 (0 or >NOF_BYTES = all)
//          in_valid - word offered
//          in_ready - block is idle and will take a word
//          out_hold - sink backpressure
//          ready    - byte strobe, dout valid while high
//          dout     - output byte (holds last byte after completion)
//          busy     - word in progress
//          done     - one-cycle pulse after the last byte's gap
// Rev    : 1.0  initial release
// ============================================================================
module data_serializer #(
  parameter int NOF_BYTES = 3,
  parameter int OUT_CLOCK = 1,
  parameter int GAP_CLOCK = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                   pclk,
  input  logic                   rstn,
  input  logic [8*NOF_BYTES-1:0] din,
  input  logic [3:0]             nbytes,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   out_hold,
  output logic                   ready,
  output logic [7:0]             dout,
  output logic                   busy,
  output logic                   done
);

  import data_ser_pkg::*;

  localparam int c_TMR_W = widthFor(maxOf(OUT_CLOCK, GAP_CLOCK));
  localparam int c_CNT_W = widthFor(NOF_BYTES);

  localparam logic [c_TMR_W-1:0] c_outLoad = c_TMR_W'(OUT_CLOCK - 1);
  localparam logic [c_TMR_W-1:0] c_gapLoad = c_TMR_W'(GAP_CLOCK - 1);

  serState_t r_state;
  serState_t w_nextState;

  logic [8*NOF_BYTES-1:0] r_buf;
  logic [c_CNT_W-1:0]     r_cnt;      // bytes whose strobe has not yet ended
  logic [c_CNT_W-1:0]     r_idx;      // index of the byte on dout
  logic [7:0]             r_dout;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;

  logic [c_CNT_W-1:0] w_effN;
  logic [c_CNT_W-1:0] w_firstIdx;
  logic [c_CNT_W-1:0] w_nextIdx;
  logic [7:0]         w_firstByte;
  logic [7:0]         w_nextByte;

  logic               w_accept;
  logic               w_toGap;
  logic               w_toStrobe;
  logic               w_finish;
  logic               w_tmrLoad;
  logic [c_TMR_W-1:0] w_tmrLoadVal;
  logic               w_tmrHold;
  logic               w_tmrZero;

  // --------------------------------------------------------------------------
  // Byte selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_effN = c_CNT_W'(nbytes);
    if ((nbytes == 4'd0) || (int'(nbytes) > NOF_BYTES)) begin
      w_effN = c_CNT_W'(NOF_BYTES);
    end
  end

  // MSB-first walks downward from the top requested byte; LSB-first walks
  // upward from byte 0. w_nextIdx is only used while bytes remain, so the
  // step never leaves the word.
  assign w_firstIdx  = (MSB_FIRST != 0) ? (w_effN - 1'b1) : '0;
  assign w_nextIdx   = (MSB_FIRST != 0) ? (r_idx - 1'b1) : (r_idx + 1'b1);
  assign w_firstByte = 8'(din   >> {w_firstIdx, 3'b000});
  assign w_nextByte  = 8'(r_buf >> {w_nextIdx,  3'b000});

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_toGap      = 1'b0;
    w_toStrobe   = 1'b0;
    w_finish     = 1'b0;
    w_tmrLoad    = 1'b0;
    w_tmrLoadVal = c_outLoad;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_tmrLoad   = 1'b1;
          w_nextState = STROBE;
        end
      end
      STROBE: begin
        if (w_tmrZero && !out_hold) begin
          w_toGap      = 1'b1;
          w_tmrLoad    = 1'b1;
          w_tmrLoadVal = c_gapLoad;
          w_nextState  = GAP;
        end
      end
      GAP: begin
        if (w_tmrZero && !out_hold) begin
          if (r_cnt != '0) begin
            w_toStrobe  = 1'b1;
            w_tmrLoad   = 1'b1;
            w_nextState = STROBE;
          end else begin
            w_finish    = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Hold only freezes an active word; in IDLE the timer is parked at zero.
  assign w_tmrHold = out_hold || (r_state == IDLE);

  ser_timer #(
    .WIDTH (c_TMR_W)
  ) u_timer (
    .pclk    (pclk),
    .rstn    (rstn),
    .load    (w_tmrLoad),
    .loadVal (w_tmrLoadVal),
    .hold    (w_tmrHold),
    .zero    (w_tmrZero)
  );

  // --------------------------------------------------------------------------
  // Datapath and status
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dout  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_nextState != IDLE);
      r_done <= w_finish;
      if (w_accept) begin
        r_buf   <= din;
        r_cnt   <= w_effN;
        r_idx   <= w_firstIdx;
        r_dout  <= w_firstByte;
        r_ready <= 1'b1;
      end else if (w_toGap) begin
        r_cnt   <= r_cnt - 1'b1;
        r_ready <= 1'b0;
      end else if (w_toStrobe) begin
        r_idx   <= w_nextIdx;
        r_dout  <= w_nextByte;
        r_ready <= 1'b1;
      end
    end
  end

  assign in_ready = (r_state == IDLE);
  assign ready    = r_ready;
  assign dout     = r_dout;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_data_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_data_serializer
// Brief  : Self-checking bench for data_serializer. Three instances:
//          0 = defaults (3 bytes, MSB first, 1/1 timing)
//          1 = 4 bytes, LSB first, 1/1 timing
//          2 = 3 bytes, MSB first, OUT_CLOCK=3, GAP_CLOCK=2
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_serializer;

  logic        pclk;
  logic        rstn;
  logic [63:0] dinv  [3];
  logic [3:0]  nb    [3];
  logic        vld   [3];
  logic        hold  [3];
  logic        inRdy [3];
  logic        rdy   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [7:0]  dout  [3];

  data_serializer #(.NOF_BYTES(3)) u_dut0 (
    .pclk(pclk), .rstn(rstn), .din(dinv[0][23:0]), .nbytes(nb[0]),
    .in_valid(vld[0]), .in_ready(inRdy[0]), .out_hold(hold[0]),
    .ready(rdy[0]), .dout(dout[0]), .busy(busy[0]), .done(done[0]));

  data_serializer #(.NOF_BYTES(4), .MSB_FIRST(0)) u_dut1 (
    .pclk(pclk), .rstn(rstn), .din(dinv[1][31:0]), .nbytes(nb[1]),
    .in_valid(vld[1]), .in_ready(inRdy[1]), .out_hold(hold[1]),
    .ready(rdy[1]), .dout(dout[1]), .busy(busy[1]), .done(done[1]));

  data_serializer #(.NOF_BYTES(3), .OUT_CLOCK(3), .GAP_CLOCK(2)) u_dut2 (
    .pclk(pclk), .rstn(rstn), .din(dinv[2][23:0]), .nbytes(nb[2]),
    .in_valid(vld[2]), .in_ready(inRdy[2]), .out_hold(hold[2]),
    .ready(rdy[2]), .dout(dout[2]), .busy(busy[2]), .done(done[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int nTests = 0;
  int nFail  = 0;

  // Monitor: sampled 1 time unit after each rising edge.
  int         cyc = 0;
  logic [7:0] bq [3][256];
  int         sq [3][256];
  int         bn [3]      = '{0, 0, 0};
  int         sn [3]      = '{0, 0, 0};
  int         runLen [3]  = '{0, 0, 0};
  logic       prevRdy [3] = '{1'b0, 1'b0, 1'b0};
  int         busyCnt [3] = '{0, 0, 0};
  int         doneCnt [3] = '{0, 0, 0};
  int         doneCyc [3] = '{0, 0, 0};

  always @(posedge pclk) begin
    #1;
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rdy[d] && !prevRdy[d]) begin
        if (bn[d] < 256) bq[d][bn[d]] = dout[d];
        bn[d] = bn[d] + 1;
        runLen[d] = 0;
      end
      if (rdy[d]) runLen[d] = runLen[d] + 1;
      if (!rdy[d] && prevRdy[d]) begin
        if (sn[d] < 256) sq[d][sn[d]] = runLen[d];
        sn[d] = sn[d] + 1;
      end
      if (busy[d]) busyCnt[d] = busyCnt[d] + 1;
      if (done[d]) begin
        doneCnt[d] = doneCnt[d] + 1;
        doneCyc[d] = cyc;
      end
      prevRdy[d] = rdy[d];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic waitDone(input int d, input int target, input string nm);
    int t;
    t = 0;
    while ((doneCnt[d] < target) && (t < 200)) begin
      @(negedge pclk);
      t++;
    end
    chk({nm, " done reached"}, 64'(doneCnt[d] >= target), 64'd1);
  endtask

  typedef struct {
    int          dut;
    logic [63:0] din;
    logic [3:0]  nbytes;
    int          nExp;
    logic [63:0] seq;      // first transmitted byte in [7:0]
    int          expBusy;
    int          strb;
  } vec_t;

  vec_t vecs [12];

  task automatic runVec(input vec_t v, input string nm);
    int d, b0, s0, bus0, dn0, k;
    logic [63:0] sq64;
    d = v.dut;
    @(negedge pclk);
    chk({nm, " in_ready"}, 64'(inRdy[d]), 64'd1);
    b0 = bn[d]; s0 = sn[d]; bus0 = busyCnt[d]; dn0 = doneCnt[d]; k = cyc;
    dinv[d] = v.din; nb[d] = v.nbytes; vld[d] = 1'b1;
    @(negedge pclk);
    vld[d] = 1'b0; dinv[d] = 64'h5A5A_5A5A_5A5A_5A5A; nb[d] = 4'd1;
    waitDone(d, dn0 + 1, nm);
    repeat (3) @(negedge pclk);
    chk({nm, " byte count"}, 64'(bn[d] - b0), 64'(v.nExp));
    sq64 = v.seq;
    for (int i = 0; i < v.nExp; i++) begin
      chk($sformatf("%s byte%0d", nm, i), 64'(bq[d][b0 + i]), 64'(sq64[8*i +: 8]));
      chk($sformatf("%s strobe%0d len", nm, i), 64'(sq[d][s0 + i]), 64'(v.strb));
    end
    chk({nm, " busy cycles"}, 64'(busyCnt[d] - bus0), 64'(v.expBusy));
    chk({nm, " done pulses"}, 64'(doneCnt[d] - dn0), 64'd1);
    chk({nm, " done cycle"}, 64'(doneCyc[d] - k), 64'(v.expBusy + 1));
    chk({nm, " dout held"}, 64'(dout[d]), 64'(sq64[8*(v.nExp-1) +: 8]));
    chk({nm, " idle ready/busy"}, 64'({rdy[d], busy[d]}), 64'd0);
  endtask

  int b0, s0, bus0, dn0, k;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 64'hA1B2C3,   4'd3,  3, 64'hC3B2A1,   6, 1};
    vecs[1]  = '{0, 64'hA1B2C3,   4'd0,  3, 64'hC3B2A1,   6, 1};
    vecs[2]  = '{0, 64'hA1B2C3,   4'd1,  1, 64'hC3,       2, 1};
    vecs[3]  = '{0, 64'hA1B2C3,   4'd2,  2, 64'hC3B2,     4, 1};
    vecs[4]  = '{0, 64'h5E6F70,   4'd9,  3, 64'h706F5E,   6, 1};
    vecs[5]  = '{1, 64'h11223344, 4'd2,  2, 64'h3344,     4, 1};
    vecs[6]  = '{1, 64'h11223344, 4'd0,  4, 64'h11223344, 8, 1};
    vecs[7]  = '{1, 64'h11223344, 4'd4,  4, 64'h11223344, 8, 1};
    vecs[8]  = '{1, 64'h11223344, 4'd15, 4, 64'h11223344, 8, 1};
    vecs[9]  = '{1, 64'h11223344, 4'd1,  1, 64'h44,       2, 1};
    vecs[10] = '{2, 64'hA1B2C3,   4'd3,  3, 64'hC3B2A1,  15, 3};
    vecs[11] = '{2, 64'hA1B2C3,   4'd2,  2, 64'hC3B2,    10, 3};

    for (int d = 0; d < 3; d++) begin
      dinv[d] = '0; nb[d] = 4'd0; vld[d] = 1'b0; hold[d] = 1'b0;
    end
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset state dut%0d", d),
          64'({rdy[d], busy[d], done[d], inRdy[d], dout[d]}), 64'({4'b0001, 8'h00}));
    end
    repeat (2) @(negedge pclk);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold for 4 cycles during the second strobe of a 3/2 timed word.
    @(negedge pclk);
    b0 = bn[2]; s0 = sn[2]; bus0 = busyCnt[2]; dn0 = doneCnt[2];
    dinv[2] = 64'hA1B2C3; nb[2] = 4'd3; vld[2] = 1'b1;
    @(negedge pclk);
    vld[2] = 1'b0;
    repeat (5) @(negedge pclk);
    chk("hold second strobe start", 64'({rdy[2], dout[2]}), 64'({1'b1, 8'hB2}));
    hold[2] = 1'b1;
    repeat (4) @(negedge pclk);
    chk("hold frozen", 64'({rdy[2], dout[2]}), 64'({1'b1, 8'hB2}));
    hold[2] = 1'b0;
    waitDone(2, dn0 + 1, "hold");
    repeat (2) @(negedge pclk);
    chk("hold byte count", 64'(bn[2] - b0), 64'd3);
    chk("hold byte0", 64'(bq[2][b0]),     64'hA1);
    chk("hold byte1", 64'(bq[2][b0 + 1]), 64'hB2);
    chk("hold byte2", 64'(bq[2][b0 + 2]), 64'hC3);
    chk("hold strobe0 len", 64'(sq[2][s0]),     64'd3);
    chk("hold strobe1 len", 64'(sq[2][s0 + 1]), 64'd7);
    chk("hold strobe2 len", 64'(sq[2][s0 + 2]), 64'd3);
    chk("hold busy cycles", 64'(busyCnt[2] - bus0), 64'd19);

    // Back-to-back words with in_valid held high.
    @(negedge pclk);
    b0 = bn[0]; bus0 = busyCnt[0]; dn0 = doneCnt[0]; k = cyc;
    dinv[0] = 64'h010203; nb[0] = 4'd3; vld[0] = 1'b1;
    @(negedge pclk);
    dinv[0] = 64'h040506;
    repeat (6) @(negedge pclk);
    chk("b2b done with in_ready", 64'({done[0], inRdy[0]}), 64'b11);
    @(negedge pclk);
    vld[0] = 1'b0;
    chk("b2b second word first byte", 64'({rdy[0], dout[0]}), 64'({1'b1, 8'h04}));
    waitDone(0, dn0 + 2, "b2b");
    repeat (2) @(negedge pclk);
    chk("b2b byte count", 64'(bn[0] - b0), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b byte%0d", i), 64'(bq[0][b0 + i]), 64'(i + 1));
    end
    chk("b2b busy cycles", 64'(busyCnt[0] - bus0), 64'd12);
    chk("b2b done pulses", 64'(doneCnt[0] - dn0), 64'd2);
    chk("b2b last done cycle", 64'(doneCyc[0] - k), 64'd14);

    // in_valid pulsed while busy with other data.
    @(negedge pclk);
    b0 = bn[0]; bus0 = busyCnt[0]; dn0 = doneCnt[0]; k = cyc;
    dinv[0] = 64'hA1B2C3; nb[0] = 4'd3; vld[0] = 1'b1;
    @(negedge pclk);
    vld[0] = 1'b0;
    @(negedge pclk);
    dinv[0] = 64'hFFEEDD; nb[0] = 4'd1; vld[0] = 1'b1;
    @(negedge pclk);
    vld[0] = 1'b0;
    waitDone(0, dn0 + 1, "ignore");
    repeat (4) @(negedge pclk);
    chk("ignore byte count", 64'(bn[0] - b0), 64'd3);
    chk("ignore byte0", 64'(bq[0][b0]),     64'hA1);
    chk("ignore byte1", 64'(bq[0][b0 + 1]), 64'hB2);
    chk("ignore byte2", 64'(bq[0][b0 + 2]), 64'hC3);
    chk("ignore busy cycles", 64'(busyCnt[0] - bus0), 64'd6);
    chk("ignore done cycle", 64'(doneCyc[0] - k), 64'd7);
    chk("ignore done pulses", 64'(doneCnt[0] - dn0), 64'd1);

    // Reset during the second byte, then a new word on the first edge.
    @(negedge pclk);
    dn0 = doneCnt[0];
    dinv[0] = 64'hA1B2C3; nb[0] = 4'd3; vld[0] = 1'b1;
    @(negedge pclk);
    vld[0] = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst pre second byte", 64'({rdy[0], dout[0]}), 64'({1'b1, 8'hB2}));
    rstn = 1'b0;
    #1;
    chk("rst async outputs", 64'({rdy[0], busy[0], done[0], inRdy[0], dout[0]}),
        64'({4'b0001, 8'h00}));
    repeat (2) @(negedge pclk);
    chk("rst no done", 64'(doneCnt[0] - dn0), 64'd0);
    b0 = bn[0]; bus0 = busyCnt[0];
    rstn = 1'b1;
    dinv[0] = 64'h040506; nb[0] = 4'd3; vld[0] = 1'b1;
    @(negedge pclk);
    vld[0] = 1'b0;
    chk("rst first edge accept", 64'({rdy[0], dout[0]}), 64'({1'b1, 8'h04}));
    waitDone(0, dn0 + 1, "rst");
    repeat (2) @(negedge pclk);
    chk("rst byte count", 64'(bn[0] - b0), 64'd3);
    chk("rst byte0", 64'(bq[0][b0]),     64'h04);
    chk("rst byte1", 64'(bq[0][b0 + 1]), 64'h05);
    chk("rst byte2", 64'(bq[0][b0 + 2]), 64'h06);
    chk("rst busy cycles", 64'(busyCnt[0] - bus0), 64'd6);
    chk("rst done pulses", 64'(doneCnt[0] - dn0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
